// File: rtl/axi_pack_rd_arbiter.sv
// rtl/axi_pack_rd_arbiter.sv - round-robin AR arbiter with in-order R routing for strided-read requesters
//
// Shares one converter read port among NumPorts requesters. AR requests are
// granted round-robin through a two-state FSM (ARB / HOLD). Each accepted AR
// pushes its port index into a route FIFO. The FIFO head steers the returning
// R beats, and a last beat pops it.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   s_ar_i/_valid_i/_ready_o   per-requester AR channel
//   s_r_o/_valid_o/_ready_i    per-requester R channel
//   m_ar_o/_valid_o/_ready_i   AR channel to the converter
//   m_r_i/_valid_i/_ready_o    R channel from the converter
//   stat_grant_cnt_o           per-requester accepted-AR counters (16 bit, saturating)
//   busy_o                     route FIFO not empty or AR being presented
//
// Optional feature: define AXI_PACK_RD_ARB_STATS_EN to build the grant counters.
// Without it, stat_grant_cnt_o is tied to zero.
//
// R payload: the LSB of the packed R payload is taken as 'last'. Declare the
// last field as the final member of the packed struct.
module axi_pack_rd_arbiter #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned FifoDepth = 8,
  parameter type axi_ssr_ar_chan_t = logic,
  parameter type axi_ssr_r_chan_t  = logic
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  axi_ssr_ar_chan_t [NumPorts-1:0]   s_ar_i,
  input  logic [NumPorts-1:0]               s_ar_valid_i,
  output logic [NumPorts-1:0]               s_ar_ready_o,
  output axi_ssr_r_chan_t [NumPorts-1:0]    s_r_o,
  output logic [NumPorts-1:0]               s_r_valid_o,
  input  logic [NumPorts-1:0]               s_r_ready_i,
  output axi_ssr_ar_chan_t                  m_ar_o,
  output logic                              m_ar_valid_o,
  input  logic                              m_ar_ready_i,
  input  axi_ssr_r_chan_t                   m_r_i,
  input  logic                              m_r_valid_i,
  output logic                              m_r_ready_o,
  output logic [NumPorts-1:0][15:0]         stat_grant_cnt_o,
  output logic                              busy_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {ST_ARB = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IdxW-1:0]  r_rr_ptr;
  logic [IdxW-1:0]  r_gnt_idx;
  axi_ssr_ar_chan_t r_ar_hold;
  logic [IdxW-1:0]  w_sel_idx;
  logic [IdxW-1:0]  w_cur_idx;
  logic             w_sel_found;
  logic             w_ar_hs;

  logic [IdxW-1:0]  r_fifo_mem [FifoDepth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_push;
  logic             w_pop;
  logic [IdxW-1:0]  w_head;
  logic [$bits(axi_ssr_r_chan_t)-1:0] w_r_bits;
  logic             w_r_last;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CntW'(FifoDepth));

  // Round-robin search starting at r_rr_ptr. A full route FIFO suppresses
  // presentation entirely, even when a last beat pops in the same cycle.
  always_comb begin
    int unsigned j;
    logic [IdxW-1:0] k;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      j = (32'(r_rr_ptr) + i) % NumPorts;
      k = IdxW'(j);
      if (!w_sel_found && !w_fifo_full && s_ar_valid_i[k]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = k;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_ARB;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: HOLD is entered only when the first presentation is not accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (w_sel_found && !m_ar_ready_i) w_state_nxt = ST_HOLD;
      ST_HOLD: if (m_ar_ready_i) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // FSM outputs. In HOLD the payload comes from the latched copy, so the
  // requester cannot disturb it while the converter stalls.
  always_comb begin
    w_cur_idx    = (r_state == ST_HOLD) ? r_gnt_idx : w_sel_idx;
    m_ar_valid_o = rst_ni && ((r_state == ST_HOLD) || w_sel_found);
    m_ar_o       = (r_state == ST_HOLD) ? r_ar_hold : s_ar_i[w_cur_idx];
    w_ar_hs      = m_ar_valid_o && m_ar_ready_i;
    s_ar_ready_o = '0;
    if (w_ar_hs) s_ar_ready_o[w_cur_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_ar_hold <= '0;
    end else begin
      if (r_state == ST_ARB && w_sel_found) begin
        r_gnt_idx <= w_sel_idx;
        r_ar_hold <= s_ar_i[w_sel_idx];
      end
      if (w_ar_hs) r_rr_ptr <= IdxW'((32'(w_cur_idx) + 32'd1) % NumPorts);
    end
  end

  // Route FIFO of granted port indices
  assign w_r_bits = m_r_i;
  assign w_r_last = w_r_bits[0];
  assign w_push   = w_ar_hs;
  assign w_pop    = m_r_valid_i && m_r_ready_o && w_r_last;

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_cur_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // R steering from the FIFO head; an empty FIFO blocks the converter
  always_comb begin
    w_head      = r_fifo_mem[r_rd_ptr];
    s_r_valid_o = '0;
    m_r_ready_o = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) s_r_o[k] = m_r_i;
    if (!w_fifo_empty) begin
      s_r_valid_o[w_head] = m_r_valid_i;
      m_r_ready_o         = s_r_ready_i[w_head];
    end
  end

  assign busy_o = (r_count != '0) || m_ar_valid_o;

`ifdef AXI_PACK_RD_ARB_STATS_EN
  logic [NumPorts-1:0][15:0] r_grant_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant_cnt <= '0;
    end else begin
      for (int k = 0; k < NumPorts; k++) begin
        if (w_ar_hs && w_cur_idx == IdxW'(k) && r_grant_cnt[k] != 16'hFFFF)
          r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
      end
    end
  end

  assign stat_grant_cnt_o = r_grant_cnt;
`else
  assign stat_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_pack_rd_arbiter.sv
// tb/tb_axi_pack_rd_arbiter.sv - self-checking bench for axi_pack_rd_arbiter
module tb_axi_pack_rd_arbiter;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
`ifdef AXI_PACK_RD_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef logic [15:0] ar_t;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } r_t;

  logic                  clk;
  logic                  rst_n;
  ar_t [NP-1:0]          s_ar;
  logic [NP-1:0]         s_ar_valid;
  logic [NP-1:0]         s_ar_ready;
  r_t [NP-1:0]           s_r;
  logic [NP-1:0]         s_r_valid;
  logic [NP-1:0]         s_r_ready;
  ar_t                   m_ar;
  logic                  m_ar_valid;
  logic                  m_ar_ready;
  r_t                    m_r;
  logic                  m_r_valid;
  logic                  m_r_ready;
  logic [NP-1:0][15:0]   stat;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;

  axi_pack_rd_arbiter #(
    .NumPorts(NP), .FifoDepth(DEPTH),
    .axi_ssr_ar_chan_t(ar_t), .axi_ssr_r_chan_t(r_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_ar_i(s_ar), .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready),
    .s_r_o(s_r), .s_r_valid_o(s_r_valid), .s_r_ready_i(s_r_ready),
    .m_ar_o(m_ar), .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready),
    .m_r_i(m_r), .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready),
    .stat_grant_cnt_o(stat), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_payloads(input logic [7:0] salt);
    for (int k = 0; k < NP; k++) s_ar[k] = {4'hA, 4'(k), salt};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_ar_valid = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r = '0; s_r_ready = '0;
    set_payloads(8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [NP-1:0] v;
    bit           rdy;
    logic [7:0]   salt;
    bit           ev;
    int           ep;
    logic [7:0]   es;
    logic [NP-1:0] esr;
  } tv_t;

  tv_t vec [12];

  // Reference model state
  int   m_rr;
  int   m_hold;
  ar_t  m_held_pl;
  int   m_route[$];
  int unsigned m_cnt [NP];

  initial begin
    rst_n = 1'b0;
    s_ar_valid = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r = '0; s_r_ready = '0;
    set_payloads(8'h00);

    // Round-robin over four continuous requesters, then a stalled grant held
    // against another requester and against its own valid/payload changing.
    vec[0]  = '{1'b1, 4'b1111, 1'b1, 8'h10, 1'b1, 0, 8'h10, 4'b0001};
    vec[1]  = '{1'b0, 4'b1111, 1'b1, 8'h11, 1'b1, 1, 8'h11, 4'b0010};
    vec[2]  = '{1'b0, 4'b1111, 1'b1, 8'h12, 1'b1, 2, 8'h12, 4'b0100};
    vec[3]  = '{1'b0, 4'b1111, 1'b1, 8'h13, 1'b1, 3, 8'h13, 4'b1000};
    vec[4]  = '{1'b0, 4'b1111, 1'b1, 8'h14, 1'b1, 0, 8'h14, 4'b0001};
    vec[5]  = '{1'b1, 4'b0100, 1'b0, 8'h20, 1'b1, 2, 8'h20, 4'b0000};
    vec[6]  = '{1'b0, 4'b0101, 1'b0, 8'h21, 1'b1, 2, 8'h20, 4'b0000};
    vec[7]  = '{1'b0, 4'b0001, 1'b0, 8'h22, 1'b1, 2, 8'h20, 4'b0000};
    vec[8]  = '{1'b0, 4'b0101, 1'b0, 8'h23, 1'b1, 2, 8'h20, 4'b0000};
    vec[9]  = '{1'b0, 4'b0101, 1'b0, 8'h24, 1'b1, 2, 8'h20, 4'b0000};
    vec[10] = '{1'b0, 4'b0101, 1'b1, 8'h25, 1'b1, 2, 8'h20, 4'b0100};
    vec[11] = '{1'b0, 4'b0001, 1'b1, 8'h26, 1'b1, 0, 8'h26, 4'b0001};

    // Reset state
    @(negedge clk); #1;
    chk("reset_m_ar_valid", 32'(m_ar_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_m_r_ready", 32'(m_r_ready), 0);
    chk("reset_stat0", 32'(stat[0]), 0);

    for (int i = 0; i < 12; i++) begin
      if (vec[i].rst) do_reset();
      @(negedge clk);
      s_ar_valid = vec[i].v;
      m_ar_ready = vec[i].rdy;
      set_payloads(vec[i].salt);
      #1;
      chk($sformatf("vec%0d_m_ar_valid", i), 32'(m_ar_valid), 32'(vec[i].ev));
      if (vec[i].ev) chk($sformatf("vec%0d_m_ar", i), 32'(m_ar), {16'h0, 4'hA, 4'(vec[i].ep), vec[i].es});
      chk($sformatf("vec%0d_s_ar_ready", i), 32'(s_ar_ready), 32'(vec[i].esr));
    end

    // Route FIFO full: eight grants, ninth withheld until one last beat retires
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_ar_valid = 4'b0010; m_ar_ready = 1'b1;
      #1;
      chk($sformatf("full_grant%0d", i), 32'(s_ar_ready), 32'b0010);
    end
    @(negedge clk); #1;
    chk("full_no_ar", 32'(m_ar_valid), 0);
    chk("full_busy", 32'(busy), 1);
    @(negedge clk);
    m_r_valid = 1'b1; m_r = '{data: 16'h5555, last: 1'b1}; s_r_ready = 4'b1111;
    #1;
    chk("full_pop_cycle_no_ar", 32'(m_ar_valid), 0);
    chk("full_pop_r_valid", 32'(s_r_valid), 32'b0010);
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    chk("full_after_pop_ar", 32'(m_ar_valid), 1);
    chk("full_after_pop_ready", 32'(s_ar_ready), 32'b0010);

    // Grants 1 then 3, four beats each, with back-pressure from port 1
    do_reset();
    @(negedge clk);
    s_ar_valid = 4'b0010; m_ar_ready = 1'b1;
    #1 chk("route_g1", 32'(s_ar_ready), 32'b0010);
    @(negedge clk);
    s_ar_valid = 4'b1000;
    #1 chk("route_g3", 32'(s_ar_ready), 32'b1000);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (p == 0 && b == 1) begin
          @(negedge clk);
          s_ar_valid = '0;
          m_r_valid = 1'b1; m_r = '{data: 16'hDEAD, last: 1'b0}; s_r_ready = 4'b1101;
          #1;
          chk("route_bp_ready", 32'(m_r_ready), 0);
          chk("route_bp_valid", 32'(s_r_valid), 32'b0010);
        end
        @(negedge clk);
        s_ar_valid = '0;
        m_r_valid = 1'b1; m_r = '{data: 16'(16'h100 * (p + 1) + b), last: (b == 3)};
        s_r_ready = 4'b1111;
        #1;
        chk($sformatf("route_p%0d_b%0d_valid", p, b), 32'(s_r_valid), (p == 0) ? 32'b0010 : 32'b1000);
        chk($sformatf("route_p%0d_b%0d_ready", p, b), 32'(m_r_ready), 1);
        chk($sformatf("route_p%0d_b%0d_data", p, b), 32'(s_r[(p == 0) ? 1 : 3].data), 32'(16'h100 * (p + 1) + b));
      end
    end
    @(negedge clk);
    m_r = '{data: 16'h0BAD, last: 1'b1};
    #1;
    chk("route_empty_ready", 32'(m_r_ready), 0);
    chk("route_empty_valid", 32'(s_r_valid), 0);
    chk("route_empty_busy", 32'(busy), 0);

    // Reset mid-burst with three bursts queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_ar_valid = 4'b0111; m_ar_ready = 1'b1;
      #1 chk($sformatf("mid_grant%0d", i), 32'(s_ar_ready), 32'(1 << i));
    end
    @(negedge clk);
    s_ar_valid = '0;
    m_r_valid = 1'b1; m_r = '{data: 16'h1234, last: 1'b0}; s_r_ready = 4'b1111;
    #1 chk("mid_beat_ready", 32'(m_r_ready), 1);
    @(negedge clk);
    s_ar_valid = 4'b1111; m_ar_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_ar_valid", 32'(m_ar_valid), 0);
    chk("mid_rst_s_ar_ready", 32'(s_ar_ready), 0);
    chk("mid_rst_m_r_ready", 32'(m_r_ready), 0);
    chk("mid_rst_s_r_valid", 32'(s_r_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_m_r_ready", 32'(m_r_ready), 0);
    chk("mid_rel_s_r_valid", 32'(s_r_valid), 0);
    chk("mid_rel_ar_valid", 32'(m_ar_valid), 1);
    chk("mid_rel_port0", 32'(m_ar[11:8]), 0);

    // Randomized traffic against the reference model
    do_reset();
    m_rr = 0; m_hold = -1; m_held_pl = '0; m_route.delete();
    for (int k = 0; k < NP; k++) m_cnt[k] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   present;
      int   head;
      ar_t  exp_pl;
      bit   r_hs_last;
      @(negedge clk);
      for (int k = 0; k < NP; k++) s_ar[k] = ar_t'($urandom);
      s_ar_valid = NP'($urandom);
      m_ar_ready = ($urandom_range(0, 1) == 1);
      m_r_valid  = ($urandom_range(0, 9) < 6);
      m_r        = '{data: 16'($urandom), last: ($urandom_range(0, 9) < 3)};
      s_r_ready  = NP'($urandom);
      #1;
      present = -1;
      if (m_hold >= 0) present = m_hold;
      else if (m_route.size() < DEPTH) begin
        for (int i = 0; i < NP; i++) begin
          if (present < 0 && s_ar_valid[(m_rr + i) % NP]) present = (m_rr + i) % NP;
        end
      end
      exp_pl = (m_hold >= 0) ? m_held_pl : ((present >= 0) ? s_ar[present] : '0);
      head = (m_route.size() > 0) ? m_route[0] : -1;

      chk("rnd_m_ar_valid", 32'(m_ar_valid), 32'(present >= 0));
      if (present >= 0) chk("rnd_m_ar", 32'(m_ar), 32'(exp_pl));
      chk("rnd_s_ar_ready", 32'(s_ar_ready), (present >= 0 && m_ar_ready) ? 32'(1 << present) : 32'd0);
      chk("rnd_s_r_valid", 32'(s_r_valid), (head >= 0 && m_r_valid) ? 32'(1 << head) : 32'd0);
      chk("rnd_m_r_ready", 32'(m_r_ready), (head >= 0) ? 32'(s_r_ready[head]) : 32'd0);
      chk("rnd_busy", 32'(busy), 32'(m_route.size() != 0 || present >= 0));
      if (head >= 0 && m_r_valid) chk("rnd_s_r_data", 32'(s_r[head]), 32'(m_r));

      r_hs_last = (head >= 0) && m_r_valid && s_r_ready[head] && m_r.last;
      if (r_hs_last) void'(m_route.pop_front());
      if (present >= 0) begin
        if (m_ar_ready) begin
          m_route.push_back(present);
          m_rr = (present + 1) % NP;
          m_hold = -1;
          if (m_cnt[present] < 32'hFFFF) m_cnt[present]++;
        end else begin
          m_hold = present;
          m_held_pl = exp_pl;
        end
      end
    end
    for (int k = 0; k < NP; k++)
      chk($sformatf("rnd_stat%0d", k), 32'(stat[k]), STATS_ON ? m_cnt[k] : 32'd0);

    // Counter saturation: 70000 grants from port 0
    do_reset();
    @(negedge clk);
    s_ar_valid = 4'b0001; m_ar_ready = 1'b1;
    m_r_valid = 1'b1; m_r = '{data: 16'h0, last: 1'b1}; s_r_ready = 4'b1111;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    #1;
    chk("sat_stat0", 32'(stat[0]), STATS_ON ? 32'hFFFF : 32'd0);
    chk("sat_stat1", 32'(stat[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
